// File: rtl/add_tree_acc.sv
// add_tree_acc: pipelined N_IN-operand signed adder tree with packet accumulation.
// Define ADD_TREE_ACC_SAT_EN for saturating accumulation with a sticky ovf flag.
module add_tree_acc #(
    parameter int N_IN  = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_mode,
    input  logic                 in_last,
    input  logic                 clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic                 out_last,
    output logic                 ovf
);

    localparam int LVL   = $clog2(N_IN);
    localparam int SUM_W = IN_W + LVL;

    logic                    out_valid_d, out_valid_q;
    logic signed [ACC_W-1:0] out_data_d, out_data_q;
    logic                    out_last_d, out_last_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    adv;

    // Every stage moves in lockstep; a stalled output freezes the whole tree.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int NO = N_IN >> (l + 1);
        localparam int OW = IN_W + l + 1;

        logic signed [OW-2:0] a_in [2*NO];
        logic signed [OW-1:0] sum_d [NO];
        logic signed [OW-1:0] sum_q [NO];
        logic                 src_vld, src_mode, src_last;
        logic                 vld_d, vld_q;
        logic                 mode_d, mode_q;
        logic                 last_d, last_q;

        if (l == 0) begin : g_src
            always_comb begin
                for (int k = 0; k < 2 * NO; k++) begin
                    a_in[k] = in_data[k*IN_W +: IN_W];
                end
            end
            assign src_vld  = in_valid;
            assign src_mode = in_mode;
            assign src_last = in_last;
        end else begin : g_src
            always_comb begin
                for (int k = 0; k < 2 * NO; k++) begin
                    a_in[k] = g_lvl[l-1].sum_q[k];
                end
            end
            assign src_vld  = g_lvl[l-1].vld_q;
            assign src_mode = g_lvl[l-1].mode_q;
            assign src_last = g_lvl[l-1].last_q;
        end

        always_comb begin
            vld_d  = vld_q;
            mode_d = mode_q;
            last_d = last_q;
            for (int k = 0; k < NO; k++) begin
                sum_d[k] = sum_q[k];
            end
            if (adv) begin
                vld_d  = src_vld;
                mode_d = src_mode;
                last_d = src_last;
                for (int k = 0; k < NO; k++) begin
                    sum_d[k] = {a_in[2*k][OW-2], a_in[2*k]}
                             + {a_in[2*k+1][OW-2], a_in[2*k+1]};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                vld_q  <= 1'b0;
                mode_q <= 1'b0;
                last_q <= 1'b0;
                for (int k = 0; k < NO; k++) begin
                    sum_q[k] <= '0;
                end
            end else begin
                vld_q  <= vld_d;
                mode_q <= mode_d;
                last_q <= last_d;
                for (int k = 0; k < NO; k++) begin
                    sum_q[k] <= sum_d[k];
                end
            end
        end
    end

    logic signed [SUM_W-1:0] tree_sum;
    logic                    t_vld, t_mode, t_last;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_nxt;

    assign tree_sum = g_lvl[LVL-1].sum_q[0];
    assign t_vld    = g_lvl[LVL-1].vld_q;
    assign t_mode   = g_lvl[LVL-1].mode_q;
    assign t_last   = g_lvl[LVL-1].last_q;
    assign sum_ext  = ACC_W'(tree_sum);
    // A clear landing with an accumulate beat restarts from that beat's sum.
    assign acc_base = clr ? '0 : acc_q;

`ifdef ADD_TREE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] acc_wide;
    logic           clip;
    logic           ovf_d, ovf_q;

    assign acc_wide = {acc_base[ACC_W-1], acc_base}
                    + {sum_ext[ACC_W-1], sum_ext};
    assign clip     = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];

    always_comb begin
        acc_nxt = acc_wide[ACC_W-1:0];
        if (clip) begin
            acc_nxt = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end
        if (adv && t_vld && t_mode && clip) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_nxt = acc_base + sum_ext;
    assign ovf     = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        acc_d       = acc_q;
        if (clr) begin
            acc_d = '0;
        end
        if (adv) begin
            out_valid_d = t_vld;
            if (t_vld) begin
                out_last_d = t_last;
                if (t_mode) begin
                    out_data_d = acc_nxt;
                    acc_d      = t_last ? '0 : acc_nxt;
                end else begin
                    out_data_d = sum_ext;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_add_tree_acc.sv
// tb_add_tree_acc: randomized and directed checks of add_tree_acc against
// an arithmetic reference model of sums, accumulation and framing.
module tb_add_tree_acc;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 24;
    localparam int AS = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b;
    logic          in_valid, in_ready, in_mode, in_last, clr;
    logic [N*W-1:0] in_data;
    logic          out_valid, out_ready, out_last, ovf;
    logic [AW-1:0] out_data;

    logic          s_valid, s_ready, s_mode, s_last, s_clr;
    logic [N*W-1:0] s_data;
    logic          s_ovalid, s_oready, s_olast, s_ovf;
    logic [AS-1:0] s_odata;

    add_tree_acc #(.N_IN(N), .IN_W(W), .ACC_W(AW)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .ovf(ovf)
    );

    add_tree_acc #(.N_IN(N), .IN_W(W), .ACC_W(AS)) dut12 (
        .clk(clk), .rst_b(rst_b),
        .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
        .in_mode(s_mode), .in_last(s_last), .clr(s_clr),
        .out_valid(s_ovalid), .out_ready(s_oready),
        .out_data(s_odata), .out_last(s_olast), .ovf(s_ovf)
    );

    typedef struct {
        longint data;
        bit     last;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  got_q[$];
    longint m_acc;
    bit     m_ovf;
    bit     did_acc;
    int     total = 0;
    int     bad = 0;

    function automatic logic [31:0] pack4(input int a, input int b,
                                          input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic longint beat_sum(input logic [31:0] d);
        longint s = 0;
        for (int k = 0; k < N; k++) begin
            s += longint'($signed(d[k*W +: W]));
        end
        return s;
    endfunction

    function automatic longint wrapw(input longint x, input int w);
        longint m = longint'(1) << w;
        longint r = x & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic void acc_step(input longint a, input longint s,
                                     input int w, output longint r,
                                     output bit clip);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint t = a + s;
`ifdef ADD_TREE_ACC_SAT_EN
        clip = (t > hi) || (t < lo);
        r = (t > hi) ? hi : ((t < lo) ? lo : t);
`else
        clip = 1'b0;
        r = wrapw(t, w);
`endif
    endfunction

    task automatic model_accept();
        beat_t  b;
        longint s = beat_sum(in_data);
        longint r;
        bit     c;
        b.last = in_last;
        if (in_mode) begin
            acc_step(m_acc, s, AW, r, c);
            if (c) m_ovf = 1'b1;
            b.data = r;
            m_acc = in_last ? 0 : r;
        end else begin
            b.data = s;
        end
        exp_q.push_back(b);
    endtask

    // One clock: record handshakes that complete at the coming edge.
    task automatic cycle();
        beat_t b;
        #1;
        did_acc = in_valid && in_ready;
        if (did_acc) model_accept();
        if (out_valid && out_ready) begin
            b.data = longint'($signed(out_data));
            b.last = out_last;
            got_q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL rst_out_data got=%0d want=0", out_data);
        end
        total++;
        if (out_last !== 1'b0 || ovf !== 1'b0 || s_ovf !== 1'b0) begin
            bad++;
            $display("FAIL rst_last_ovf got=%b%b%b want=000",
                     out_last, ovf, s_ovf);
        end
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_pass();
        int lat;
        got_q.delete();
        exp_q.delete();
        in_mode = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        in_data = pack4(-1, 1, -47, 29);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL pass_latency got=%0d want=3", lat);
        end
        total++;
        if (longint'($signed(out_data)) != -18) begin
            bad++;
            $display("FAIL pass_sum got=%0d want=-18", $signed(out_data));
        end
        in_data = pack4(-128, -128, -128, -128);
        in_valid = 1'b1;
        cycle();
        drain(6);
        total++;
        if (got_q.size() != 2) begin
            bad++;
            $display("FAIL pass_count got=%0d want=2", got_q.size());
        end else begin
            total++;
            if (got_q[1].data != -512) begin
                bad++;
                $display("FAIL pass_min got=%0d want=-512", got_q[1].data);
            end
        end
    endtask

    task automatic test_accum();
        longint want [3] = '{10, 110, 4};
        bit     wl [3] = '{1'b0, 1'b1, 1'b1};
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        in_mode = 1'b1;
        in_valid = 1'b1;
        in_data = pack4(1, 2, 3, 4);
        in_last = 1'b0;
        cycle();
        in_data = pack4(10, 20, 30, 40);
        in_last = 1'b1;
        cycle();
        in_data = pack4(1, 1, 1, 1);
        in_last = 1'b1;
        cycle();
        drain(6);
        in_mode = 1'b0;
        in_last = 1'b0;
        total++;
        if (got_q.size() != 3) begin
            bad++;
            $display("FAIL acc_count got=%0d want=3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_q[i].data != want[i] || got_q[i].last != wl[i]) begin
                    bad++;
                    $display("FAIL acc_beat%0d got=%0d/%b want=%0d/%b", i,
                             got_q[i].data, got_q[i].last, want[i], wl[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] beats [8];
        int sent = 0;
        int cyc = 0;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) beats[i] = $urandom();
        in_mode = 1'b0;
        while (got_q.size() < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 9);
            in_valid = (sent < 8);
            in_data = beats[sent < 8 ? sent : 7];
            in_last = (sent == 7);
            #1;
            if (cyc == 4) begin
                total++;
                if (in_ready !== 1'b0 || exp_q.size() - got_q.size() != 3) begin
                    bad++;
                    $display("FAIL bp_full got=%b/%0d want=0/3", in_ready,
                             exp_q.size() - got_q.size());
                end
            end
            if (cyc > 4 && cyc <= 9) begin
                total++;
                if (out_valid !== 1'b1 || longint'($signed(out_data))
                    != exp_q[got_q.size()].data) begin
                    bad++;
                    $display("FAIL bp_hold%0d got=%b/%0d want=1/%0d", cyc,
                             out_valid, $signed(out_data),
                             exp_q[got_q.size()].data);
                end
            end
            cycle();
            if (did_acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        total++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            bad++;
            $display("FAIL bp_count got=%0d/%0d want=8", got_q.size(),
                     exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i].data != exp_q[i].data ||
                    got_q[i].last != exp_q[i].last) begin
                    bad++;
                    $display("FAIL bp_beat%0d got=%0d want=%0d", i,
                             got_q[i].data, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        int errs = 0;
        got_q.delete();
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_data = $urandom();
            in_mode = $urandom_range(0, 1) == 1;
            in_last = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain(10);
        in_mode = 1'b0;
        in_last = 1'b0;
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rnd_count got=%0d want=%0d", got_q.size(),
                     exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                total++;
                if (got_q[i].data != exp_q[i].data ||
                    got_q[i].last != exp_q[i].last) begin
                    bad++;
                    errs++;
                    if (errs < 5)
                        $display("FAIL rnd_beat%0d got=%0d/%b want=%0d/%b", i,
                                 got_q[i].data, got_q[i].last,
                                 exp_q[i].data, exp_q[i].last);
                end
            end
        end
        total++;
        if (ovf !== m_ovf) begin
            bad++;
            $display("FAIL rnd_ovf got=%b want=%b", ovf, m_ovf);
        end
    endtask

    task automatic test_clr();
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        m_acc = 0;
        in_mode = 1'b1;
        in_last = 1'b0;
        in_data = pack4(25, 25, 25, 25);
        in_valid = 1'b1;
        cycle();
        drain(5);
        total++;
        if (got_q.size() != 1 || got_q[0].data != 100) begin
            bad++;
            $display("FAIL clr_pre got=%0d want=100",
                     got_q.size() > 0 ? got_q[0].data : -1);
        end
        in_data = pack4(5, 5, 5, 5);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        total++;
        if (out_valid !== 1'b1 || longint'($signed(out_data)) != 20) begin
            bad++;
            $display("FAIL clr_coincide got=%b/%0d want=1/20", out_valid,
                     $signed(out_data));
        end
        drain(4);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        got_q.delete();
        in_data = pack4(1, 1, 1, 1);
        in_last = 1'b1;
        in_valid = 1'b1;
        cycle();
        drain(5);
        total++;
        if (got_q.size() != 1 || got_q[0].data != 4) begin
            bad++;
            $display("FAIL clr_alone got=%0d want=4",
                     got_q.size() > 0 ? got_q[0].data : -1);
        end
        in_mode = 1'b0;
        in_last = 1'b0;
        m_acc = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overflow();
        longint outs[$];
        longint a = 0;
        longint r;
        bit     c;
        bit     o = 1'b0;
        longint want5;
        s_oready = 1'b1;
        s_mode = 1'b1;
        s_last = 1'b0;
        s_data = pack4(127, 127, 127, 127);
        for (int i = 0; i < 14; i++) begin
            s_valid = (i < 6);
            #1;
            if (s_ovalid) outs.push_back(longint'($signed(s_odata)));
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (outs.size() != 6) begin
            bad++;
            $display("FAIL ovf_count got=%0d want=6", outs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                acc_step(a, beat_sum(s_data), AS, r, c);
                a = r;
                if (c) o = 1'b1;
                total++;
                if (outs[i] != r) begin
                    bad++;
                    $display("FAIL ovf_beat%0d got=%0d want=%0d", i,
                             outs[i], r);
                end
            end
`ifdef ADD_TREE_ACC_SAT_EN
            want5 = 2047;
`else
            want5 = -1556;
`endif
            total++;
            if (outs[4] != want5) begin
                bad++;
                $display("FAIL ovf_fifth got=%0d want=%0d", outs[4], want5);
            end
        end
        total++;
        if (s_ovf !== o) begin
            bad++;
            $display("FAIL ovf_flag got=%b want=%b", s_ovf, o);
        end
        s_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_clr = 1'b0;
        total++;
        if (s_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr got=%b want=0", s_ovf);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_main got=%b want=0", ovf);
        end
    endtask

    task automatic test_reset_flight();
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        in_mode = 1'b1;
        in_last = 1'b0;
        in_data = pack4(10, 10, 10, 10);
        in_valid = 1'b1;
        cycle();
        drain(5);
        in_data = pack4(7, 7, 7, 7);
        in_valid = 1'b1;
        cycle();
        in_data = pack4(9, 9, 9, 9);
        cycle();
        in_valid = 1'b0;
        cycle();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rf_pre got=%b want=1", out_valid);
        end
        #2;
        rst_b = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL rf_async got=%b/%0d want=0/0", out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        in_data = pack4(3, 4, 5, 6);
        in_valid = 1'b1;
        cycle();
        drain(6);
        total++;
        if (got_q.size() != 1 || got_q[0].data != 18) begin
            bad++;
            $display("FAIL rf_first got=%0d/%0d want=1/18", got_q.size(),
                     got_q.size() > 0 ? got_q[0].data : -1);
        end
        in_mode = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 1'b0;
        in_last = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_mode = 1'b0;
        s_last = 1'b0;
        s_clr = 1'b0;
        s_oready = 1'b1;
        m_acc = 0;
        m_ovf = 1'b0;
        did_acc = 1'b0;
        #1 rst_b = 1'b0;
        test_reset();
        test_pass();
        test_accum();
        test_back_to_back();
        test_random();
        test_clr();
        test_overflow();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
